// File: rtl/function_unit_seq.sv
// function_unit_seq: registered ALU/shifter for the register-file datapath,
// with an iterative shift-add multiply behind a start/busy/done handshake.
module function_unit_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       FS,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] F,
    output logic             V,
    output logic             C,
    output logic             N,
    output logic             Z,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_n;

    logic [WIDTH-1:0]   mcand, mplier, opb, res;
    logic [2*WIDTH-1:0] acc, acc_n;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;
    logic               cin, c_r, v_r;

    // Arithmetic ops share one adder: A + opb + cin
    always_comb begin
        opb = '0;
        cin = 1'b0;
        case (FS[2:0])
            3'b001:  cin = 1'b1;
            3'b010:  opb = B;
            3'b011:  begin opb = B; cin = 1'b1; end
            3'b100:  opb = ~B;
            3'b101:  begin opb = ~B; cin = 1'b1; end
            3'b110:  opb = '1;
            default: opb = '0;
        endcase
        sum = {1'b0, A} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
        case (FS[2:0])
            3'b000:  res = A & B;
            3'b001:  res = A | B;
            3'b010:  res = A ^ B;
            3'b011:  res = ~A;
            3'b100:  res = B;
            3'b101:  res = B >> 1;
            3'b110:  res = B << 1;
            default: res = '0;
        endcase
        res = FS[3] ? res : sum[WIDTH-1:0];
        c_r = !FS[3] && sum[WIDTH];
        v_r = !FS[3] && (A[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        acc_n = acc + (mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (start && FS == 4'hF) ? MUL : IDLE;
            default: state_n = (cnt == LAST) ? IDLE : MUL;
        endcase
    end

    assign busy = (state == MUL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            F      <= '0;
            V      <= 1'b0;
            C      <= 1'b0;
            N      <= 1'b0;
            Z      <= 1'b0;
            done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                if (FS == 4'hF) begin
                    mcand  <= A;
                    mplier <= B;
                    acc    <= '0;
                    cnt    <= '0;
                end else begin
                    F    <= res;
                    C    <= c_r;
                    V    <= v_r;
                    N    <= res[WIDTH-1];
                    Z    <= (res == '0);
                    done <= 1'b1;
                end
            end else if (state == MUL) begin
                acc    <= acc_n;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == LAST) begin
                    F    <= acc_n[WIDTH-1:0];
                    C    <= |acc_n[2*WIDTH-1:WIDTH];
                    V    <= 1'b0;
                    N    <= acc_n[WIDTH-1];
                    Z    <= (acc_n[WIDTH-1:0] == '0);
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_function_unit_seq.sv
// tb_function_unit_seq: directed and random checks against an arithmetic
// reference model of the function unit.
module tb_function_unit_seq;
    logic        clk, reset, start;
    logic [3:0]  FS;
    logic [15:0] A, B, F;
    logic        V, C, N, Z, busy, done;
    int          n_cmp = 0, n_err = 0;

    function_unit_seq #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .FS(FS), .A(A), .B(B),
        .F(F), .V(V), .C(C), .N(N), .Z(Z), .busy(busy), .done(done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {V, C, F} for one operation, from the arithmetic definition
    function automatic logic [17:0] model(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] nb, f;
        longint x, ci, u, s, sa, sx, p;
        logic c, v;
        nb = ~b;
        x = 0; ci = 0; c = 0; v = 0; f = 0;
        case (fs)
            4'd1: ci = 1;
            4'd2: x = longint'(b);
            4'd3: begin x = longint'(b); ci = 1; end
            4'd4: x = longint'(nb);
            4'd5: begin x = longint'(nb); ci = 1; end
            4'd6: x = 65535;
            default: ;
        endcase
        if (fs < 8) begin
            u  = longint'(a) + x + ci;
            sa = (a >= 16'h8000) ? longint'(a) - 65536 : longint'(a);
            sx = (x >= 32768) ? x - 65536 : x;
            s  = sa + sx + ci;
            f  = u[15:0];
            c  = (u >= 65536);
            v  = (s > 32767) || (s < -32768);
        end else begin
            case (fs)
                4'd8:  f = a & b;
                4'd9:  f = a | b;
                4'd10: f = a ^ b;
                4'd11: f = ~a;
                4'd12: f = b;
                4'd13: f = b / 2;
                4'd14: f = 16'((longint'(b) * 2) % 65536);
                default: begin
                    p = longint'(a) * longint'(b);
                    f = 16'(p % 65536);
                    c = (p >= 65536);
                end
            endcase
        end
        return {v, c, f};
    endfunction

    task automatic op(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                      input bit poke, output int lat, output int nbusy);
        @(negedge clk);
        start = 1; FS = fs; A = a; B = b;
        lat = 0; nbusy = 0;
        do begin
            @(posedge clk); #1;
            start = 0;
            lat++;
            if (busy) nbusy++;
            if (poke && lat == 3) begin
                start = 1; A = 16'd1; B = 16'd1;
            end
        end while (!done && lat < 40);
    endtask

    task automatic check_res(input string tag, input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b);
        logic [17:0] e;
        e = model(fs, a, b);
        check({tag, ".F"}, 32'(F), 32'(e[15:0]));
        check({tag, ".VC"}, 32'({V, C}), 32'(e[17:16]));
        check({tag, ".NZ"}, 32'({N, Z}), 32'({e[15], e[15:0] == 16'h0}));
    endtask

    initial begin
        int lat, nb;
        logic [3:0]  fs;
        logic [15:0] a, b;
        reset = 1; start = 0; FS = 0; A = 0; B = 0;
        #2 reset = 0;
        #1;
        check("reset.F", 32'(F), 0);
        check("reset.flags", 32'({V, C, N, Z, busy, done}), 0);
        @(negedge clk) reset = 1;

        op(4'b0010, 16'h7FFF, 16'h0001, 0, lat, nb);
        check("add.lat", lat, 1);
        check("add.F", 32'(F), 32'h8000);
        check("add.VCNZ", 32'({V, C, N, Z}), 32'b1010);
        @(posedge clk); #1;
        check("add.done_pulse", 32'(done), 0);
        check("add.hold", 32'(F), 32'h8000);

        op(4'b0101, 16'h1234, 16'h1234, 0, lat, nb);
        check("sub.F", 32'(F), 0);
        check("sub.VCNZ", 32'({V, C, N, Z}), 32'b0101);
        op(4'b0110, 16'h0000, 16'h0000, 0, lat, nb);
        check("dec.F", 32'(F), 32'hFFFF);
        check("dec.VCN", 32'({V, C, N}), 32'b001);
        op(4'b1101, 16'h0000, 16'h8001, 0, lat, nb);
        check("shr.F", 32'(F), 32'h4000);
        check("shr.VC", 32'({V, C}), 0);
        op(4'b1110, 16'h0000, 16'h8001, 0, lat, nb);
        check("shl.F", 32'(F), 32'h0002);
        op(4'b1010, 16'hFF00, 16'h0FF0, 0, lat, nb);
        check("xor.F", 32'(F), 32'hF0F0);

        op(4'b1111, 16'd300, 16'd300, 1, lat, nb);
        check("mul.lat", lat, 17);
        check("mul.busy_cycles", nb, 16);
        check("mul.F", 32'(F), 32'h5F90);
        check("mul.C", 32'(C), 1);
        check("mul.busy_end", 32'(busy), 0);

        // abort a multiply partway through with an asynchronous reset
        @(negedge clk);
        start = 1; FS = 4'hF; A = 16'd7; B = 16'd9;
        @(posedge clk); #1 start = 0;
        repeat (8) @(posedge clk);
        #3 reset = 0;
        #1;
        check("abort.F", 32'(F), 0);
        check("abort.flags", 32'({V, C, N, Z, busy, done}), 0);
        @(negedge clk) reset = 1;

        op(4'b1111, 16'd7, 16'd9, 0, lat, nb);
        check("mul79.F", 32'(F), 32'd63);
        check("mul79.C", 32'(C), 0);
        start = 1; FS = 4'b0001; A = 16'd5;
        @(posedge clk); #1 start = 0;
        check("b2b.done", 32'(done), 1);
        check("b2b.F", 32'(F), 32'd6);

        for (int i = 0; i < 300; i++) begin
            fs = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (i % 5 == 0) a = (i % 2) ? 16'h8000 : 16'hFFFF;
            if (i % 7 == 0) b = (i % 3) ? 16'h0000 : 16'h7FFF;
            op(fs, a, b, 0, lat, nb);
            check($sformatf("rnd%0d.lat", i), lat, (fs == 4'hF) ? 17 : 1);
            check_res($sformatf("rnd%0d_fs%0h", i, fs), fs, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
